// File: rtl/rk4_pkg.sv
// Shared types and constants for the RK4 step sequencer.
package rk4_pkg;

  // Sequencer states: one evaluation per stage, then the state update.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_KREQ,
    ST_KACK,
    ST_UPD,
    ST_WAIT,
    ST_DONE
  } rk4_state_e;

  // Step pacing mode, taken from sel when a run is started.
  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_PACED  = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_RSVD   = 2'b11
  } rk4_mode_e;

  // Stage indices as seen by the datapath argument muxes.
  localparam logic [1:0] STG_K1 = 2'd0;
  localparam logic [1:0] STG_K2 = 2'd1;
  localparam logic [1:0] STG_K3 = 2'd2;
  localparam logic [1:0] STG_K4 = 2'd3;

  // k2 and k3 carry weight 2 in the RK4 sum, k1 and k4 weight 1.
  function automatic logic stage_is_x2(input logic [1:0] stg);
    return (stg == STG_K2) || (stg == STG_K3);
  endfunction

endpackage

// File: rtl/rk4_step_ctrl_if.sv
// Evaluator handshake and accumulator/update strobes between the sequencer
// (master) and the RK4 datapath (slave).
interface rk4_step_ctrl_if;
  logic       eval_req;
  logic       eval_ack;
  logic [1:0] stage;
  logic       acc_clr;
  logic       acc_en;
  logic       acc_wt2;
  logic       y_upd;

  modport master (
    output eval_req, stage, acc_clr, acc_en, acc_wt2, y_upd,
    input  eval_ack
  );

  modport slave (
    input  eval_req, stage, acc_clr, acc_en, acc_wt2, y_upd,
    output eval_ack
  );
endinterface

// File: rtl/rk4_tick_edge.sv
// Rising-edge detector for the clk_1Hz pacing level with a pending-tick
// latch. A tick is only collected while armed and is held until cleared.
module rk4_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  input  logic arm_i,
  input  logic clr_i,
  output logic tick_o
);

  logic lvl_q;
  logic pend_q;
  logic pend_d;
  logic rise;

  assign rise   = lvl_i & ~lvl_q;
  // A fresh edge is usable in the same cycle; an older one comes from pend_q.
  assign tick_o = arm_i & (pend_q | rise);
  assign pend_d = clr_i ? 1'b0 : (pend_q | (rise & arm_i));

  // Level history and pending-tick register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      lvl_q  <= lvl_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/rk4_step_ctrl.sv
// RK4 step sequencer: runs k1..k4 on a shared evaluator, strobes the
// weighted accumulator and the y/t update, counts and paces steps.
module rk4_step_ctrl
  import rk4_pkg::*;
#(
  parameter int STEP_W  = 16,
  parameter int TMO_W   = 12,
  parameter int TMO_MAX = 4000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          sel,
  input  logic                clk_1Hz,
  input  logic                start,
  input  logic                abort,
  input  logic [STEP_W-1:0]   n_steps,
  rk4_step_ctrl_if.master     ev,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [STEP_W-1:0]   step_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  rk4_state_e        state_q, state_d;
  rk4_mode_e         mode_q, mode_d;
  logic [1:0]        stage_q, stage_d;
  logic [STEP_W-1:0] n_steps_q, n_steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] cnt_inc;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              entry_q;
  logic              start_ok;
  logic              tick;
  logic              tick_arm;
  logic              tick_clr;

  // Reserved mode never starts a run.
  assign start_ok = start && (rk4_mode_e'(sel) != MODE_RSVD);

  // Step counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + STEP_W'(1);

  // Ticks only count while waiting; leaving WAIT discards any stale one.
  assign tick_arm = (state_q == ST_WAIT);
  assign tick_clr = !tick_arm || (en && tick);

  rk4_tick_edge u_tick (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  (clk_1Hz),
    .arm_i  (tick_arm),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Next-state and datapath-register logic.
  always_comb begin
    // NOTE: every signal gets its default first so no latch is inferred.
    state_d    = state_q;
    mode_d     = mode_q;
    stage_d    = stage_q;
    n_steps_d  = n_steps_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    tmo_d      = '0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            n_steps_d  = n_steps;
            mode_d     = rk4_mode_e'(sel);
            step_cnt_d = '0;
            err_d      = 1'b0;
            state_d    = (n_steps == '0) ? ST_DONE : ST_PREP;
          end
        end
        ST_PREP: begin
          if (en) state_d = ST_KREQ;
        end
        ST_KREQ: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (ev.eval_ack) begin
            state_d = ST_KACK;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_KACK: begin
          if (en) begin
            if (stage_q == STG_K4) begin
              state_d = ST_UPD;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = ST_KREQ;
            end
          end
        end
        ST_UPD: begin
          step_cnt_d = cnt_inc;
          if ((cnt_inc == n_steps_q) || (mode_q == MODE_SINGLE)) begin
            state_d = ST_DONE;
          end else if (mode_q == MODE_PACED) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_PREP;
          end
        end
        ST_WAIT: begin
          if (en && tick) state_d = ST_PREP;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Every step restarts at k1, and an idle sequencer presents stage 0.
    if ((state_d == ST_PREP) || (state_d == ST_IDLE)) stage_d = STG_K1;
  end

  // State and run registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FREE;
      stage_q    <= STG_K1;
      n_steps_q  <= '0;
      step_cnt_q <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      entry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      stage_q    <= stage_d;
      n_steps_q  <= n_steps_d;
      step_cnt_q <= step_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      // First cycle in a state; keeps clr/add single-cycle while held by en.
      entry_q    <= (state_d != state_q);
    end
  end

  assign ev.eval_req = (state_q == ST_KREQ);
  assign ev.stage    = stage_q;
  assign ev.acc_clr  = (state_q == ST_PREP) && entry_q;
  assign ev.acc_en   = (state_q == ST_KACK) && entry_q;
  assign ev.acc_wt2  = ev.acc_en && stage_is_x2(stage_q);
  assign ev.y_upd    = (state_q == ST_UPD);

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign step_cnt = step_cnt_q;

endmodule
